// File: rtl/scalar_wb_arbiter.sv
// scalar_wb_arbiter: shares the scalar register file's single write port between
// requester 0 (ALU) and requester 1 (memory load). Each requester owns a one-entry
// holding slot; a round-robin arbiter drains one slot per cycle into registered
// write-port outputs. When two pending slots target the same register, the older
// entry wins, so register write order matches program order.
// Optional feature: define SCALAR_WB_CONFLICT_CNT_EN to add the 16-bit saturating
// conflictCount output, which counts cycles where both slots are valid.
module scalar_wb_arbiter #(
    parameter int unsigned registerSize     = 8,
    parameter int unsigned registerQuantity = 4,
    parameter int unsigned selectionBits    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     aluValid,
    input  logic [selectionBits-1:0] aluReg,
    input  logic [registerSize-1:0]  aluData,
    output logic                     aluReady,
    input  logic                     memValid,
    input  logic [selectionBits-1:0] memReg,
    input  logic [registerSize-1:0]  memData,
    output logic                     memReady,
    output logic                     regWrEn,
    output logic [selectionBits-1:0] regToWrite,
    output logic [registerSize-1:0]  dataIn,
    output logic                     busy
`ifdef SCALAR_WB_CONFLICT_CNT_EN
    ,
    output logic [15:0]              conflictCount
`endif
);

    // The index width must address exactly the register file.
    if (registerQuantity != (1 << selectionBits)) begin : g_param_check
        $error("selectionBits does not match registerQuantity");
    end

    // Slot 0 belongs to the ALU, slot 1 to the memory load.
    logic [1:0]               slot_valid_q, slot_valid_d;
    logic [1:0]               slot_young_q, slot_young_d;
    logic [selectionBits-1:0] slot_reg_q  [2];
    logic [registerSize-1:0]  slot_data_q [2];
    logic                     rr_ptr_q, rr_ptr_d;
    logic [1:0]               grant;
    logic [1:0]               accept;
    logic                     wr_en_d;
    logic [selectionBits-1:0] wr_reg_d;
    logic [registerSize-1:0]  wr_data_d;

    // Pick which slot drains this cycle: same destination resolves by age, else round-robin.
    always_comb begin
        grant = 2'b00;
        unique case (slot_valid_q)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (slot_reg_q[0] != slot_reg_q[1]) begin
                    grant = rr_ptr_q ? 2'b10 : 2'b01;
                end else if (slot_young_q[0]) begin
                    grant = 2'b10;
                end else begin
                    // Slot 1 younger, or both captured together: ALU first, load lands last.
                    grant = 2'b01;
                end
            end
            default: grant = 2'b00;
        endcase
    end

    // Ready depends only on state, so there is no valid-to-ready combinational path.
    assign aluReady = ~slot_valid_q[0] | grant[0];
    assign memReady = ~slot_valid_q[1] | grant[1];
    assign accept   = {memValid & memReady, aluValid & aluReady};
    assign busy     = slot_valid_q[0] | slot_valid_q[1] | regWrEn;

    // Next slot occupancy, age flags, round-robin pointer and write-port values.
    always_comb begin
        slot_valid_d = (slot_valid_q & ~grant) | accept;
        // A slot that stays valid cannot be refilled, so it is always the older one.
        slot_young_d[0] = accept[0] & slot_valid_q[1] & ~grant[1];
        slot_young_d[1] = accept[1] & slot_valid_q[0] & ~grant[0];
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = 1'b0;
        wr_reg_d  = regToWrite;
        wr_data_d = dataIn;
        if (grant[0]) begin
            rr_ptr_d  = 1'b1;
            wr_en_d   = 1'b1;
            wr_reg_d  = slot_reg_q[0];
            wr_data_d = slot_data_q[0];
        end else if (grant[1]) begin
            rr_ptr_d  = 1'b0;
            wr_en_d   = 1'b1;
            wr_reg_d  = slot_reg_q[1];
            wr_data_d = slot_data_q[1];
        end
    end

    // Control state and registered write-port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid_q <= 2'b00;
            slot_young_q <= 2'b00;
            rr_ptr_q     <= 1'b0;
            regWrEn      <= 1'b0;
            regToWrite   <= '0;
            dataIn       <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_young_q <= slot_young_d;
            rr_ptr_q     <= rr_ptr_d;
            regWrEn      <= wr_en_d;
            regToWrite   <= wr_reg_d;
            dataIn       <= wr_data_d;
        end
    end

    // Slot payload capture on each accepted handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_reg_q[0]  <= '0;
            slot_reg_q[1]  <= '0;
            slot_data_q[0] <= '0;
            slot_data_q[1] <= '0;
        end else begin
            if (accept[0]) begin
                slot_reg_q[0]  <= aluReg;
                slot_data_q[0] <= aluData;
            end
            if (accept[1]) begin
                slot_reg_q[1]  <= memReg;
                slot_data_q[1] <= memData;
            end
        end
    end

`ifdef SCALAR_WB_CONFLICT_CNT_EN
    // Saturating count of cycles where one requester is stalled behind the other.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflictCount <= 16'h0000;
        end else if ((&slot_valid_q) && (conflictCount != 16'hFFFF)) begin
            conflictCount <= conflictCount + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Bench for scalar_wb_arbiter: directed scenarios with literal expectations, plus a
// timestamp-based reference model checked against the DUT on every falling edge.
module tb_scalar_wb_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       aluValid = 1'b0;
    logic [1:0] aluReg = 2'd0;
    logic [7:0] aluData = 8'h00;
    logic       aluReady;
    logic       memValid = 1'b0;
    logic [1:0] memReg = 2'd0;
    logic [7:0] memData = 8'h00;
    logic       memReady;
    logic       regWrEn;
    logic [1:0] regToWrite;
    logic [7:0] dataIn;
    logic       busy;
`ifdef SCALAR_WB_CONFLICT_CNT_EN
    logic [15:0] conflictCount;
`endif

    int vectors = 0;
    int miscompares = 0;

    scalar_wb_arbiter #(
        .registerSize     (8),
        .registerQuantity (4),
        .selectionBits    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .aluValid   (aluValid),
        .aluReg     (aluReg),
        .aluData    (aluData),
        .aluReady   (aluReady),
        .memValid   (memValid),
        .memReg     (memReg),
        .memData    (memData),
        .memReady   (memReady),
        .regWrEn    (regWrEn),
        .regToWrite (regToWrite),
        .dataIn     (dataIn),
        .busy       (busy)
`ifdef SCALAR_WB_CONFLICT_CNT_EN
        ,
        .conflictCount (conflictCount)
`endif
    );

    initial forever #5 clk = ~clk;

    task automatic cmp(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // Reference model: each slot remembers the cycle it was filled in.
    bit         m_v [2];
    logic [1:0] m_reg [2];
    logic [7:0] m_dat [2];
    int         m_stamp [2];
    int         m_rr = 0;
    int         cyc = 0;
    int         m_cnt = 0;
    bit         e_we = 0;
    logic [1:0] e_reg = 2'd0;
    logic [7:0] e_dat = 8'h00;

    function automatic int pick();
        if (!m_v[0] && !m_v[1]) return -1;
        if (!m_v[1]) return 0;
        if (!m_v[0]) return 1;
        if (m_reg[0] != m_reg[1]) return m_rr;
        if (m_stamp[1] < m_stamp[0]) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_v[0] = 0; m_v[1] = 0;
        m_rr = 0; m_cnt = 0;
        e_we = 0; e_reg = 2'd0; e_dat = 8'h00;
    endtask

    task automatic model_step();
        int g;
        bit a0, a1;
        g  = pick();
        a0 = aluValid && (!m_v[0] || g == 0);
        a1 = memValid && (!m_v[1] || g == 1);
        if (m_v[0] && m_v[1] && m_cnt < 65535) m_cnt = m_cnt + 1;
        if (g >= 0) begin
            e_we  = 1;
            e_reg = m_reg[g];
            e_dat = m_dat[g];
            m_v[g] = 0;
            m_rr = 1 - g;
        end else begin
            e_we = 0;
        end
        if (a0) begin
            m_v[0] = 1; m_reg[0] = aluReg; m_dat[0] = aluData; m_stamp[0] = cyc;
        end
        if (a1) begin
            m_v[1] = 1; m_reg[1] = memReg; m_dat[1] = memData; m_stamp[1] = cyc;
        end
        cyc++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    // Compare DUT against the model away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            cmp("m_regWrEn", int'(regWrEn), int'(e_we));
            cmp("m_regToWrite", int'(regToWrite), int'(e_reg));
            cmp("m_dataIn", int'(dataIn), int'(e_dat));
            cmp("m_busy", int'(busy), int'(m_v[0] || m_v[1] || e_we));
            cmp("m_aluReady", int'(aluReady), int'(!m_v[0] || pick() == 0));
            cmp("m_memReady", int'(memReady), int'(!m_v[1] || pick() == 1));
`ifdef SCALAR_WB_CONFLICT_CNT_EN
            cmp("m_conflictCount", int'(conflictCount), m_cnt);
`endif
        end
    end

    // Register file contents as seen through the write port.
    logic [7:0] obs_rf [4];
    always @(posedge clk) begin
        if (regWrEn) obs_rf[regToWrite] <= dataIn;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        aluValid = 0;
        memValid = 0;
        reset = 1;
        #1;
        cmp("rst_regWrEn", int'(regWrEn), 0);
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_regToWrite", int'(regToWrite), 0);
        cmp("rst_dataIn", int'(dataIn), 0);
        cmp("rst_aluReady", int'(aluReady), 1);
        cmp("rst_memReady", int'(memReady), 1);
        tick();
        reset = 0;
    endtask

    initial begin
        bit ar, mr;
        tick();

        // Single write: visible one edge after capture, then idle.
        do_reset();
        aluValid = 1; aluReg = 2'd1; aluData = 8'hFE;
        tick();
        aluValid = 0;
        cmp("t1_e0_regWrEn", int'(regWrEn), 0);
        cmp("t1_e0_busy", int'(busy), 1);
        tick();
        cmp("t1_regWrEn", int'(regWrEn), 1);
        cmp("t1_regToWrite", int'(regToWrite), 1);
        cmp("t1_dataIn", int'(dataIn), 8'hFE);
        tick();
        cmp("t1_idle_regWrEn", int'(regWrEn), 0);
        cmp("t1_idle_busy", int'(busy), 0);

        // Round-robin with both requesters always valid.
        do_reset();
        aluValid = 1; aluReg = 2'd1; aluData = 8'h10;
        memValid = 1; memReg = 2'd3; memData = 8'h80;
        for (int i = 0; i < 7; i++) begin
            ar = aluReady;
            mr = memReady;
            tick();
            if (ar) aluData = aluData + 8'd1;
            if (mr) memData = memData + 8'd1;
            if (i >= 1) begin
                cmp("t2_regWrEn", int'(regWrEn), 1);
                cmp("t2_regToWrite", int'(regToWrite), (i % 2 == 1) ? 1 : 3);
                cmp("t2_dataIn", int'(dataIn),
                    (i % 2 == 1) ? (8'h10 + (i - 1) / 2) : (8'h80 + (i - 2) / 2));
                cmp("t2_aluReady", int'(aluReady), (i % 2 == 0) ? 1 : 0);
                cmp("t2_memReady", int'(memReady), (i % 2 == 1) ? 1 : 0);
            end
        end

        // Reset while both slots hold entries: nothing stale may be written.
        do_reset();
        tick();
        cmp("t6_regWrEn_a", int'(regWrEn), 0);
        cmp("t6_busy", int'(busy), 0);
        tick();
        cmp("t6_regWrEn_b", int'(regWrEn), 0);

        // Same destination, load captured while the ALU entry is still pending.
        do_reset();
        aluValid = 1; aluReg = 2'd3; aluData = 8'h33;
        tick();
        aluReg = 2'd2; aluData = 8'h11;
        memValid = 1; memReg = 2'd0; memData = 8'h55;
        tick();
        aluValid = 0; memReg = 2'd2; memData = 8'h22;
        tick();
        memValid = 0;
        cmp("t3_first_reg", int'(regToWrite), 0);
        cmp("t3_first_data", int'(dataIn), 8'h55);
        tick();
        cmp("t3_old_reg", int'(regToWrite), 2);
        cmp("t3_old_data", int'(dataIn), 8'h11);
        tick();
        cmp("t3_new_reg", int'(regToWrite), 2);
        cmp("t3_new_data", int'(dataIn), 8'h22);
        tick();
        cmp("t3_rf2", int'(obs_rf[2]), 8'h22);

        // Same edge, same destination, with the pointer favouring the load.
        do_reset();
        aluValid = 1; aluReg = 2'd1; aluData = 8'h01;
        tick();
        aluReg = 2'd3; aluData = 8'hAA;
        memValid = 1; memReg = 2'd3; memData = 8'hBB;
        tick();
        aluValid = 0; memValid = 0;
        cmp("t4_pre_data", int'(dataIn), 8'h01);
        tick();
        cmp("t4_alu_data", int'(dataIn), 8'hAA);
        cmp("t4_alu_reg", int'(regToWrite), 3);
        tick();
        cmp("t4_mem_data", int'(dataIn), 8'hBB);
        tick();
        cmp("t4_rf3", int'(obs_rf[3]), 8'hBB);
        cmp("t4_idle_busy", int'(busy), 0);

        // Load streams alone: one write per cycle.
        do_reset();
        memValid = 1; memReg = 2'd2; memData = 8'h40;
        for (int i = 0; i < 5; i++) begin
            cmp("t5_memReady", int'(memReady), 1);
            tick();
            memData = memData + 8'd1;
            if (i >= 1) begin
                cmp("t5_regWrEn", int'(regWrEn), 1);
                cmp("t5_dataIn", int'(dataIn), 8'h40 + i - 1);
            end
        end
        memValid = 0;
        tick();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scalar_wb_arbiter.md
Name: scalar_wb_arbiter

Overview:
- Shares the single write port of the scalar register file between two writeback requesters: requester 0 (ALU) and requester 1 (memory load).
- Each requester has a one-entry holding slot with a valid/ready handshake.
- A round-robin arbiter drains one slot per cycle into registered write-port outputs (regWrEn, regToWrite, dataIn).
- The block sits between the execute/memory stages and the scalarRegisterFile write inputs.

Parameters:
- registerSize, 8, data width of a scalar register
- registerQuantity, 4, number of scalar registers
- selectionBits, 2, width of a register index (log2 of registerQuantity)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- aluValid  in  1  requester 0 has a write
- aluReg  in  selectionBits  requester 0 destination register
- aluData  in  registerSize  requester 0 write data
- aluReady  out  1  requester 0 slot can accept
- memValid  in  1  requester 1 has a write
- memReg  in  selectionBits  requester 1 destination register
- memData  in  registerSize  requester 1 write data
- memReady  out  1  requester 1 slot can accept
- regWrEn  out  1  write enable to the register file
- regToWrite  out  selectionBits  destination index to the register file
- dataIn  out  registerSize  write data to the register file
- busy  out  1  any slot valid or regWrEn high

Behaviour:
- Reset (asynchronous, active-high): both slots invalid; regWrEn=0, regToWrite=0, dataIn=0; rrPtr=0 (requester 0 has first priority); age flags cleared; busy=0.
- Handshake:
  - A transfer occurs on a rising edge where xValid && xReady.
  - The slot captures reg and data and sets slotValid.
  - xReady = ~slotValid_x | grant_x; ready is combinational from state only, with no path from valid.
  - A requester can therefore sustain one write per cycle when it is always granted.
- Age: when a slot is captured while the other slot is already valid, the new slot is marked younger.
  - When both are captured on the same edge, neither is marked younger.
- Arbitration (combinational, every cycle):
  - Only one slot valid: grant it.
  - Both valid, different destination registers: grant the requester indicated by rrPtr.
  - Both valid, same destination register: grant the older slot (the one not marked younger). If they were captured on the same edge, grant requester 0, then requester 1, so the memory load wins the final value.
- Drain: on the edge after a grant, the granted slot's reg and data are copied to regToWrite/dataIn with regWrEn=1, and the slot is cleared unless refilled on the same edge.
  - rrPtr then points to the non-granted requester.
  - With no grant, regWrEn=0 and regToWrite/dataIn hold their last values.
- Latency: capture at edge E0, outputs valid after E1, register file written at E2. Minimum of 2 cycles from accept to data readable.
- Simultaneous refill: a slot that is granted and refilled on the same edge holds the new entry as valid, with the age flag recomputed against the other slot.
- busy = slotValid0 | slotValid1 | regWrEn.
- Reset mid-operation: pending slot contents are discarded with no write issued, and regWrEn drops immediately.

Optional Feature:
- Macro SCALAR_WB_CONFLICT_CNT_EN.
- When defined:
  - Adds output conflictCount (16 bits).
  - The counter increments on every cycle where both slots are valid (one requester stalled), saturates at 16'hFFFF, and resets to 0.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Single write: after reset, aluValid=1, aluReg=1, aluData=8'hFE for one cycle → regWrEn=1 with regToWrite=1, dataIn=8'hFE exactly one cycle later; busy falls after the write.
- Round-robin: both valid every cycle, alu→reg 1 / mem→reg 3 with incrementing data → writes alternate alu, mem, alu, mem, and each ready toggles accordingly. With SCALAR_WB_CONFLICT_CNT_EN, conflictCount increments each contended cycle.
- Same-destination ordering: alu captures reg 2 = 8'h11, one cycle later mem captures reg 2 = 8'h22 while alu is pending → writes issue 8'h11 then 8'h22; a scalarRegisterFile read of reg 2 returns 8'h22.
- Same-edge same-destination: both capture reg 3 on one edge (alu 8'hAA, mem 8'hBB) → alu written first, final value 8'hBB.
- Back-pressure: mem held valid with no alu traffic → memReady stays 1 and mem sustains one write per cycle for 4 cycles (regWrEn high 4 consecutive cycles).
- Reset mid-operation: both slots full, assert reset asynchronously → regWrEn=0, busy=0, and both readies=1 after release, with no stale write issued.
